// File: rtl/pwm_trip_zone.sv
// pwm_trip_zone: fault trip-zone stage forcing safe gate levels on a qualified fault; ports clk/reset, pwm_onoff, pwmout_A_x/B_x in, fault_n/filt_len filter, trip_state_A/B, trip_mode, carr_event, trip_clear in; gated_A_x/B_x, trip_active, trip_flag, trip_int (and trip_count when PWM_TRIP_COUNT_EN is defined) out
module pwm_trip_zone #(
  parameter int PWM_WIDTH  = 8,
  parameter int FILT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm_onoff,
  input  logic [PWM_WIDTH-1:0]  pwmout_A_x,
  input  logic [PWM_WIDTH-1:0]  pwmout_B_x,
  input  logic                  fault_n,
  input  logic [FILT_WIDTH-1:0] filt_len,
  input  logic [PWM_WIDTH-1:0]  trip_state_A,
  input  logic [PWM_WIDTH-1:0]  trip_state_B,
  input  logic                  trip_mode,
  input  logic                  carr_event,
  input  logic                  trip_clear,
  output logic [PWM_WIDTH-1:0]  gated_A_x,
  output logic [PWM_WIDTH-1:0]  gated_B_x,
  output logic                  trip_active,
  output logic                  trip_flag,
  output logic                  trip_int
`ifdef PWM_TRIP_COUNT_EN
  ,
  output logic [15:0]           trip_count
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, TRIP_OS = 2'd2, TRIP_CBC = 2'd3} state_t;
  state_t state, nxt;
  logic sync1, sync2;
  logic [FILT_WIDTH-1:0] cnt;
  logic fault_s, qual, entry, clr;
  assign fault_s = ~sync2;
  assign qual    = fault_s && (cnt >= filt_len);
  assign clr     = trip_clear && !qual;
  // both trip states share state[1]; the trip flavour is captured only at entry
  assign entry   = nxt[1] && !state[1];
  always_comb begin
    nxt = state;
    case (state)
      IDLE, RUN: nxt = qual ? (trip_mode ? TRIP_CBC : TRIP_OS) : RUN;
      TRIP_OS:   nxt = clr ? RUN : TRIP_OS;
      TRIP_CBC:  nxt = (carr_event && !qual) ? RUN : TRIP_CBC;
      default:   nxt = IDLE;
    endcase
    if (!pwm_onoff) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      cnt         <= '0;
      gated_A_x   <= '0;
      gated_B_x   <= '0;
      trip_active <= 1'b0;
      trip_flag   <= 1'b0;
      trip_int    <= 1'b0;
    end else begin
      state       <= nxt;
      sync1       <= fault_n;
      sync2       <= sync1;
      cnt         <= !fault_s ? '0 : (&cnt) ? cnt : cnt + 1'b1;
      gated_A_x   <= (nxt == RUN) ? pwmout_A_x : nxt[1] ? trip_state_A : '0;
      gated_B_x   <= (nxt == RUN) ? pwmout_B_x : nxt[1] ? trip_state_B : '0;
      trip_active <= nxt[1];
      trip_flag   <= entry || (trip_flag && !clr);
      trip_int    <= entry;
    end
  end
`ifdef PWM_TRIP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) trip_count <= '0;
    else trip_count <= entry ? ((&trip_count) ? trip_count : trip_count + 16'd1) : clr ? 16'd0 : trip_count;
  end
`endif
endmodule
